data_serializer: RTL and testbench
==================================

# data_serializer

Downstream transmit stage of the memory access controller. It captures a parallel memory word when the controller pulses `SampleData`, then shifts the word out one bit per clock on `DataOut` while `TxData` requests transmission. When the last bit has gone out, it returns the one-cycle `TxDone` pulse that releases the controller's read flow.

## Interface
- `DATA_WIDTH`, default 8: width of the captured word and the number of data bits shifted out (≥2).
- `MSB_FIRST`, default 1: 1 sends bit `DATA_WIDTH-1` first; 0 sends bit 0 first.

- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `DataIn`  in  DATA_WIDTH  parallel word from memory, sampled on `SampleData`.
- `SampleData`  in  1  capture strobe from the controller.
- `TxData`  in  1  transmit request from the controller (level).
- `DataOut`  out  1  serial data bit, registered.
- `DataValid`  out  1  high while `DataOut` carries a valid bit.
- `TxBusy`  out  1  high from transfer start until the `TxDone` cycle ends.
- `TxDone`  out  1  one-cycle completion pulse.

## Operation
- Reset (`Reset`=0) values:
  - state IDLE; shift register, bit counter, `DataOut`, `DataValid`, `TxBusy` and `TxDone` all 0.
  - Reset takes effect immediately, including mid-shift; no `TxDone` is issued for an aborted transfer.
- States: IDLE, LOADED, SHIFT, DONE.
- IDLE:
  - `SampleData`=1 → latch `DataIn` into the shift register, go to LOADED.
  - `TxData`=1 with no sample → go to SHIFT and transmit the current register contents. This avoids a controller deadlock.
  - If both are high, the sample wins, then go to LOADED. `TxData` is re-evaluated on the next cycle.
- LOADED:
  - `SampleData`=1 → re-latch `DataIn` (last sample wins) and stay in LOADED.
  - Otherwise `TxData`=1 → go to SHIFT, bit counter = 0.
- SHIFT:
  - Each cycle, drive the next bit onto `DataOut` with `DataValid`=1, then increment the counter.
  - After bit `DATA_WIDTH-1` (or the parity bit when configured), go to DONE.
  - `SampleData` and `TxData` are ignored; deasserting `TxData` does not abort the transfer.
- DONE:
  - `TxDone`=1 for exactly one cycle, `DataValid`=0, `DataOut`=0, then go to IDLE.
  - A `SampleData` in this cycle is ignored.
- Bit order:
  - `MSB_FIRST`=1: `DataIn[DATA_WIDTH-1]` … `DataIn[0]`.
  - `MSB_FIRST`=0: the reverse order.
- The bit counter is `$clog2(DATA_WIDTH+1)` bits wide and never wraps during a legal transfer.
- `DataOut` is 0 whenever `DataValid`=0.

## Timing
- `SampleData` high at edge k → word held from k; state is LOADED after k.
- `TxData` first seen high at edge m (state LOADED):
  - First bit is on `DataOut` in the cycle after m.
  - Bit i is valid in cycle m+1+i.
- `TxDone`:
  - Without parity: high in cycle m+1+`DATA_WIDTH`.
  - With parity: high in cycle m+2+`DATA_WIDTH`.
- `TxBusy` rises in cycle m+1 and falls after the `TxDone` cycle.
- A new transfer can start at the earliest 1 cycle after `TxDone`: IDLE → sample → LOADED → shift.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_PARITY_EN` defined:
  - After the last data bit, one extra bit is sent with `DataValid`=1: even parity, the XOR of all `DATA_WIDTH` captured bits.
  - Transfer length is `DATA_WIDTH+1` bits.
- Undefined: no parity logic; transfer length is exactly `DATA_WIDTH` bits.

## Test plan
- Reset mid-shift:
  - Stimulus: `Reset` low during bit 3 of a transfer.
  - Required: all outputs 0 immediately; no `TxDone`; next transfer correct after release.
- MSB-first transfer:
  - Stimulus: `DATA_WIDTH`=8, `MSB_FIRST`=1; `SampleData` with `DataIn`=8'hA5, then `TxData`.
  - Required: `DataOut` = 1,0,1,0,0,1,0,1 in cycles m+1..m+8 with `DataValid`=1; `TxDone` one cycle at m+9; `TxBusy` spans m+1..m+9.
- LSB-first transfer:
  - Stimulus: `MSB_FIRST`=0, `DataIn`=8'h01.
  - Required: `DataOut` = 1 then seven 0s.
- Sample rules:
  - Stimulus: two `SampleData` strobes in LOADED (8'h3C, then 8'hC3) → `TxData`.
  - Required: 8'hC3 is transmitted.
  - Stimulus: `SampleData` with 8'hFF during SHIFT.
  - Required: ignored; the in-flight word is unchanged.
- Request handling:
  - Stimulus: `TxData` dropped after 2 bits.
  - Required: all 8 bits still sent, then `TxDone`.
  - Stimulus: `TxData` in IDLE with no prior sample after reset.
  - Required: eight 0 bits, then `TxDone`.
- Parity:
  - Stimulus: `SERIAL_PARITY_EN` defined, `DataIn`=8'h07.
  - Required: 8 data bits then parity bit 1 at m+9; `TxDone` at m+10.
  - Stimulus: `DataIn`=8'hA5.
  - Required: parity bit 0.

Source files
------------

// File: rtl/data_serializer.sv
// Parallel-to-serial transmit stage: captures a memory word on SampleData and shifts it out on TxData.
// Optional even-parity trailer bit is enabled by defining SERIAL_PARITY_EN.
module data_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  SampleData,
    input  logic                  TxData,
    output logic                  DataOut,
    output logic                  DataValid,
    output logic                  TxBusy,
    output logic                  TxDone
);

    localparam int CW      = $clog2(DATA_WIDTH + 1);
    localparam int SEQ_LEN = 2 ** CW;
`ifdef SERIAL_PARITY_EN
    localparam int TX_BITS = DATA_WIDTH + 1;
`else
    localparam int TX_BITS = DATA_WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(TX_BITS - 1);

    typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [CW-1:0]         cnt_inc;
    logic                  dout_reg, dout_next;
    logic                  valid_reg, valid_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;

    // The word stays intact; bits are picked in transmit order from this
    // table, padded to a power of two so the counter indexes it exactly.
    logic [SEQ_LEN-1:0]    bit_seq;

    genvar gi;
    generate
        for (gi = 0; gi < SEQ_LEN; gi++) begin : g_seq
            if (gi < DATA_WIDTH) begin : g_data
                if (MSB_FIRST != 0) begin : g_msb
                    assign bit_seq[gi] = data_reg[DATA_WIDTH-1-gi];
                end else begin : g_lsb
                    assign bit_seq[gi] = data_reg[gi];
                end
            end else if (gi == DATA_WIDTH) begin : g_par
`ifdef SERIAL_PARITY_EN
                assign bit_seq[gi] = ^data_reg;
`else
                assign bit_seq[gi] = 1'b0;
`endif
            end else begin : g_pad
                assign bit_seq[gi] = 1'b0;
            end
        end
    endgenerate

    assign cnt_inc = cnt_reg + 1'b1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            cnt_reg   <= '0;
            dout_reg  <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        dout_next  = 1'b0;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            // IDLE may start on stale contents so the controller never deadlocks.
            IDLE, LOADED: begin
                if (SampleData) begin
                    data_next  = DataIn;
                    state_next = LOADED;
                end else if (TxData) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    dout_next  = bit_seq[0];
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            SHIFT: begin
                busy_next = 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next   = cnt_inc;
                    dout_next  = bit_seq[cnt_inc];
                    valid_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign DataOut   = dout_reg;
    assign DataValid = valid_reg;
    assign TxBusy    = busy_reg;
    assign TxDone    = done_reg;

endmodule

// File: tb/tb_data_serializer.sv
// Scoreboard bench for data_serializer: MSB-first and LSB-first instances share stimulus;
// expected bit streams come from a word-level model, checked by a negedge monitor.
module tb_data_serializer;

    localparam int W = 8;
`ifdef SERIAL_PARITY_EN
    localparam int LEN = W + 1;
`else
    localparam int LEN = W;
`endif

    logic         Clk        = 1'b0;
    logic         Reset      = 1'b1;
    logic [W-1:0] DataIn     = '0;
    logic         SampleData = 1'b0;
    logic         TxData     = 1'b0;
    logic dout_m, dv_m, busy_m, done_m;
    logic dout_l, dv_l, busy_l, done_l;

    data_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .SampleData(SampleData), .TxData(TxData),
        .DataOut(dout_m), .DataValid(dv_m), .TxBusy(busy_m), .TxDone(done_m)
    );

    data_serializer #(.DATA_WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .SampleData(SampleData), .TxData(TxData),
        .DataOut(dout_l), .DataValid(dv_l), .TxBusy(busy_l), .TxDone(done_l)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int xfer_no = 0;

    typedef struct {
        bit is_done;
        bit bm;
        bit bl;
        int cyc;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] held = '0;
    bit           mon_en = 1'b0;

    function automatic void chk(string nm, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Word-level model: bit i of the stream appears i cycles after the start edge.
    function automatic void push_bits(input logic [W-1:0] w, input int m, input int nbits, input bit with_done);
        bit p;
        p = ($countones(w) % 2) == 1;
        for (int i = 0; i < nbits; i++) begin
            exp_t e;
            e.is_done = 1'b0;
            e.cyc     = m + i;
            if (i < W) begin
                e.bm = w[W-1-i];
                e.bl = w[i];
            end else begin
                e.bm = p;
                e.bl = p;
            end
            q.push_back(e);
        end
        if (with_done) begin
            exp_t e;
            e.is_done = 1'b1;
            e.bm      = 1'b0;
            e.bl      = 1'b0;
            e.cyc     = m + LEN;
            q.push_back(e);
        end
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        if (mon_en && Reset) begin
            if (!dv_m) chk("dout_zero_m", dout_m, 0);
            if (!dv_l) chk("dout_zero_l", dout_l, 0);
            chk("busy_m", busy_m, dv_m | done_m);
            chk("busy_l", busy_l, dv_l | done_l);
            if (dv_m | dv_l | done_m | done_l) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {dv_m, done_m, dv_l, done_l}, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("valid_m", dv_m, !e.is_done);
                    chk("valid_l", dv_l, !e.is_done);
                    chk("done_m", done_m, e.is_done);
                    chk("done_l", done_l, e.is_done);
                    if (!e.is_done) begin
                        chk("bit_m", dout_m, e.bm);
                        chk("bit_l", dout_l, e.bl);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("output_present", dv_m | dv_l | done_m | done_l, 1);
            end
        end
    end

    task automatic drive(input bit s, input bit t, input logic [W-1:0] d);
        @(negedge Clk);
        SampleData = s;
        TxData     = t;
        DataIn     = d;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < LEN + 20) begin
            @(negedge Clk);
            k++;
        end
        #1;
        chk("queue_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dout_m"}, dout_m, 0);
        chk({tag, "_dv_m"},   dv_m,   0);
        chk({tag, "_busy_m"}, busy_m, 0);
        chk({tag, "_done_m"}, done_m, 0);
        chk({tag, "_dout_l"}, dout_l, 0);
        chk({tag, "_dv_l"},   dv_l,   0);
        chk({tag, "_busy_l"}, busy_l, 0);
        chk({tag, "_done_l"}, done_l, 0);
    endtask

    // drop: number of start-relative edges TxData stays high (1..LEN+1).
    task automatic transfer(input logic [W-1:0] word, input bit do_samp, input bit simul,
                            input int drop, input bit samp_shift, input bit samp_done);
        int m;
        if (simul) begin
            drive(1'b1, 1'b1, word);
            held = word;
            drive(1'b0, 1'b1, word);
        end else begin
            if (do_samp) begin
                drive(1'b1, 1'b0, word);
                held = word;
            end
            drive(1'b0, 1'b1, word);
        end
        @(posedge Clk);
        #1;
        m = cyc;
        push_bits(held, m, LEN, 1'b1);
        xfer_no++;
        $display("[TB] xfer %0d: word=%h sampled=%0d simul=%0d drop=%0d shift_samp=%0d done_samp=%0d start=%0d",
                 xfer_no, held, do_samp, simul, drop, samp_shift, samp_done, m);
        for (int k = 0; k <= LEN; k++) begin
            drive((samp_shift && k == 2) || (samp_done && k == LEN), (k + 1 < drop), '1);
        end
        drive(1'b0, 1'b0, '0);
        drain();
    endtask

    task automatic reset_mid(input logic [W-1:0] word);
        int m;
        drive(1'b1, 1'b0, word);
        held = word;
        drive(1'b0, 1'b1, word);
        @(posedge Clk);
        #1;
        m = cyc;
        push_bits(word, m, 3, 1'b0);
        drive(1'b0, 1'b0, word);
        repeat (3) @(posedge Clk);
        #1;
        chk("bit3_m", dout_m, word[W-4]);
        chk("bit3_l", dout_l, word[3]);
        Reset = 1'b0;
        held  = '0;
        #1;
        check_all_zero("midreset");
        $display("[TB] reset asserted during bit 3 of word=%h start=%0d", word, m);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (LEN + 3) @(negedge Clk);
        chk("no_pending_after_reset", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #1 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        Reset  = 1'b1;
        mon_en = 1'b1;

        transfer(8'h00, 1'b0, 1'b0, LEN + 1, 1'b0, 1'b0);   // IDLE request, nothing sampled
        transfer(8'hA5, 1'b1, 1'b0, LEN + 1, 1'b0, 1'b0);
        transfer(8'h01, 1'b1, 1'b0, LEN + 1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h3C);
        transfer(8'hC3, 1'b1, 1'b0, LEN + 1, 1'b0, 1'b0);   // last sample wins
        transfer(8'hA5, 1'b1, 1'b0, LEN + 1, 1'b1, 1'b0);   // 8'hFF during SHIFT
        transfer(8'h5A, 1'b1, 1'b0, 2, 1'b0, 1'b0);         // request dropped early
        transfer(8'h07, 1'b1, 1'b0, LEN + 1, 1'b0, 1'b0);
        transfer(8'h96, 1'b1, 1'b0, LEN + 1, 1'b0, 1'b1);   // 8'hFF during DONE
        transfer(8'h00, 1'b0, 1'b0, LEN + 1, 1'b0, 1'b0);   // resends retained 8'h96
        transfer(8'hC3, 1'b1, 1'b1, LEN + 1, 1'b0, 1'b0);   // sample and request together
        reset_mid(8'hB6);
        transfer(8'h00, 1'b0, 1'b0, LEN + 1, 1'b0, 1'b0);   // register cleared by reset
        transfer(8'h6D, 1'b1, 1'b0, LEN + 1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int ex;
            int gap;
            ex  = $urandom_range(0, 2);
            gap = $urandom_range(0, 2);
            for (int s = 0; s < ex; s++) drive(1'b1, 1'b0, W'($urandom));
            transfer(W'($urandom), 1'b1, $urandom_range(0, 3) == 0, $urandom_range(1, LEN + 1),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            repeat (gap) @(negedge Clk);
        end

        repeat (4) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
